// File: rtl/mem_bank_pkg.sv
// Shared types and helpers for the mem_bank storage block: FSM states,
// reset-fill modes, the fill-pattern function and per-byte parity.
package mem_pkg;

  typedef enum logic {
    MB_INIT,
    MB_RUN
  } mb_state_t;

  localparam int MB_INIT_ZERO = 0;
  localparam int MB_INIT_ADDR = 1;

  // Widest data word the parity helper handles.
  localparam int MB_MAX_W = 256;

  function automatic logic [31:0] init_word(input int mode, input logic [31:0] addr);
    logic [31:0] w;
    w = '0;
    if (mode == MB_INIT_ADDR) begin
      w = addr;
    end
    return w;
  endfunction

  // Even parity: stored bit makes the byte plus parity carry an even number of ones.
  function automatic logic [MB_MAX_W/8-1:0] byte_parity(input logic [MB_MAX_W-1:0] data);
    logic [MB_MAX_W/8-1:0] p;
    p = '0;
    for (int b = 0; b < MB_MAX_W / 8; b++) begin
      p[b] = ^data[8*b +: 8];
    end
    return p;
  endfunction

endpackage

// File: rtl/mem_bank_rd_pipe.sv
// Read-response delay line: LAT stages of {valid, err, perr, rdata},
// cleared asynchronously so in-flight reads vanish on reset.
module mem_rd_pipe #(
  parameter int DATA_W = 32,
  parameter int LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_rdata,
  input  logic              in_err,
  input  logic              in_perr,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_rdata,
  output logic              out_err,
  output logic              out_perr
);

  localparam int SW = DATA_W + 3;

  logic [SW-1:0] stage_reg [LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        stage_reg[i] <= '0;
      end
    end else begin
      stage_reg[0] <= {in_valid, in_err, in_perr, in_rdata};
      for (int i = 1; i < LAT; i++) begin
        stage_reg[i] <= stage_reg[i-1];
      end
    end
  end

  assign {out_valid, out_err, out_perr, out_rdata} = stage_reg[LAT-1];

endmodule

// File: rtl/mem_bank.sv
// Single-port memory bank with valid/ready requests, byte enables, RD_LAT read
// pipeline and a DEPTH-cycle reset fill. Optional parity: MEM_BANK_PARITY_EN.
module mem_bank
  import mem_pkg::*;
#(
  parameter int  DATA_W    = 32,
  parameter int  DEPTH     = 512,
  parameter int  RD_LAT    = 1,
  parameter int  INIT_MODE = MB_INIT_ADDR,
  localparam int AW        = $clog2(DEPTH),
  localparam int NB        = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [NB-1:0]     req_be,
  input  logic [AW-1:0]     req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_perr,
  output logic              init_done
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  mb_state_t     state_reg, state_next;
  logic [AW-1:0] init_ptr_reg, init_ptr_next;

  logic              accept, addr_ok, wr_fire, rd_fire;
  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [NB-1:0]     mem_wbe;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] fill_word;
  logic [DATA_W-1:0] rd_word;
  logic [NB-1:0]     lane_perr;
  logic              rd_perr;

  logic              pipe_valid, pipe_err, pipe_perr;
  logic [DATA_W-1:0] pipe_rdata;
  logic [DATA_W-1:0] rdata_hold_reg;

  // ---------------- init / run sequencer ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= MB_INIT;
      init_ptr_reg <= '0;
    end else begin
      state_reg    <= state_next;
      init_ptr_reg <= init_ptr_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    init_ptr_next = init_ptr_reg;
    case (state_reg)
      MB_INIT: begin
        init_ptr_next = init_ptr_reg + AW'(1);
        if (init_ptr_reg == LAST_ADDR) begin
          state_next    = MB_RUN;
          init_ptr_next = '0;
        end
      end
      MB_RUN: begin
        state_next = MB_RUN;
      end
      default: begin
        state_next = MB_INIT;
      end
    endcase
  end

  assign req_ready = (state_reg == MB_RUN);
  assign init_done = (state_reg == MB_RUN);

  // ---------------- request decode ----------------
  generate
    if (DEPTH == (1 << AW)) begin : g_pow2
      assign addr_ok = 1'b1;
    end else begin : g_npow2
      assign addr_ok = (req_addr < AW'(DEPTH));
    end
  endgenerate

  assign accept  = req_valid & req_ready;
  assign wr_fire = accept & req_we & addr_ok;
  assign rd_fire = accept & ~req_we;

  assign fill_word = DATA_W'(init_word(INIT_MODE, 32'(init_ptr_reg)));

  // The fill sequencer owns the write port until the bank enters RUN.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = req_addr;
    mem_wbe   = req_be;
    mem_wdata = req_wdata;
    if (state_reg == MB_INIT) begin
      mem_we    = 1'b1;
      mem_waddr = init_ptr_reg;
      mem_wbe   = '1;
      mem_wdata = fill_word;
    end else if (wr_fire) begin
      mem_we = 1'b1;
    end
  end

`ifdef MEM_BANK_PARITY_EN
  logic [NB-1:0] wr_par;
  assign wr_par = NB'(byte_parity(MB_MAX_W'(mem_wdata)));
`endif

  // ---------------- storage, one byte lane per generate slice ----------------
  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      logic [7:0] data_q [DEPTH];
      logic       lane_we;

      assign lane_we = mem_we & mem_wbe[gi];

      always_ff @(posedge clk) begin
        if (lane_we) begin
          data_q[mem_waddr] <= mem_wdata[8*gi +: 8];
        end
      end

      assign rd_word[8*gi +: 8] = data_q[req_addr];

`ifdef MEM_BANK_PARITY_EN
      logic par_q [DEPTH];

      always_ff @(posedge clk) begin
        if (lane_we) begin
          par_q[mem_waddr] <= wr_par[gi];
        end
      end

      assign lane_perr[gi] = par_q[req_addr] ^ (^data_q[req_addr]);
`else
      assign lane_perr[gi] = 1'b0;
`endif
    end
  endgenerate

  assign rd_perr = |lane_perr;

  // ---------------- response path ----------------
  // The first pipe stage is the array's read register.
  mem_rd_pipe #(
    .DATA_W (DATA_W),
    .LAT    (RD_LAT)
  ) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_fire),
    .in_rdata  (addr_ok ? rd_word : '0),
    .in_err    (rd_fire & ~addr_ok),
    .in_perr   (rd_fire & addr_ok & rd_perr),
    .out_valid (pipe_valid),
    .out_rdata (pipe_rdata),
    .out_err   (pipe_err),
    .out_perr  (pipe_perr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_hold_reg <= '0;
    end else if (pipe_valid) begin
      rdata_hold_reg <= pipe_rdata;
    end
  end

  assign rsp_valid = pipe_valid;
  assign rsp_rdata = pipe_valid ? pipe_rdata : rdata_hold_reg;
  assign rsp_err   = pipe_err;
  assign rsp_perr  = pipe_perr;

endmodule

// File: doc/mem_bank.md
Name: mem_bank

Overview:
- Parametrised single-port synchronous memory bank; next generation of the microprocessor's data/instruction memory.
- Adds a valid/ready request interface, per-byte write enables and a configurable read-latency pipeline.
- Replaces single-cycle array clear with a multi-cycle reset-init sequencer and an out-of-range error response.
- Sits between the core's load/store unit and storage; one bank instance per address space.

Parameters:
- DATA_W, 32, data word width in bits; must be a multiple of 8.
- DEPTH, 512, number of words; need not be a power of two.
- RD_LAT, 1, read latency in cycles from request acceptance to response; legal range 1..4.
- INIT_MODE, 1, reset fill pattern: 0 = all zero, 1 = word[i] = i (zero-extended or truncated to DATA_W).

Ports:
- clk, in, 1, clock; all state updates on rising edge.
- rst, in, 1, asynchronous active-high reset.
- req_valid, in, 1, request present.
- req_ready, out, 1, bank can accept a request this cycle.
- req_we, in, 1, 1 = write, 0 = read.
- req_be, in, DATA_W/8, per-byte write enable; bit k covers bits [8k+7:8k]; ignored on reads.
- req_addr, in, AW = $clog2(DEPTH), word address.
- req_wdata, in, DATA_W, write data.
- rsp_valid, out, 1, read response valid (single-cycle pulse per read).
- rsp_rdata, out, DATA_W, read data; holds last value when rsp_valid=0.
- rsp_err, out, 1, response is for an out-of-range address; qualified by rsp_valid.
- rsp_perr, out, 1, parity error on response; qualified by rsp_valid; tied 0 unless the optional feature is compiled in.
- init_done, out, 1, high once the reset fill is complete.

Behaviour:
- Reset is async, active-high, on clk domain.
  - Outputs during and after reset: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_perr=0, init_done=0.
  - Reset flushes the read pipeline and enters INIT with init pointer = 0.
- INIT state:
  - Writes one word per cycle at the init pointer using the INIT_MODE pattern; pointer increments each cycle.
  - Occupies exactly DEPTH cycles after rst deasserts.
  - req_ready=0 throughout; requests are ignored.
  - Exit: after the write at DEPTH-1, go to RUN. init_done=1 and req_ready=1 from the next cycle onward.
- RUN state:
  - req_ready=1 constantly; fully pipelined, so one request is accepted per cycle.
  - Accept condition: req_valid & req_ready at a rising edge.
- Writes:
  - Bytes with req_be=1 are updated at the accept edge; other bytes are unchanged.
  - be=0 is a legal no-op.
  - Writes produce no response.
- Reads:
  - rsp_valid=1 exactly RD_LAT cycles after the accept edge, with rsp_rdata = word contents at the accept edge.
  - Back-to-back reads produce back-to-back responses in request order.
- Ordering:
  - A write accepted at edge N is visible to a read accepted at edge N+1 or later.
  - No read and write occur in the same cycle (single port).
- Out-of-range (addr >= DEPTH, possible only when DEPTH is not a power of two):
  - Write: dropped; memory unchanged.
  - Read: response still issued at RD_LAT with rsp_rdata=0 and rsp_err=1.
- Reset mid-operation: in-flight reads are discarded (no response after reset) and INIT restarts from address 0.
- States: INIT -> RUN only; RUN -> INIT only via rst.

Optional Feature:
- Macro: MEM_BANK_PARITY_EN.
- Defined:
  - Bank stores one even-parity bit per byte; parity is written with each byte update and with the init fill.
  - On read, rsp_perr=1 if any byte's stored parity mismatches its data.
  - Testbench hook: hierarchical force of a parity bit.
- Undefined: no parity storage; rsp_perr tied 0.

Decomposition:
- Package mem_pkg holds:
  - State enum typedef {MB_INIT, MB_RUN}.
  - INIT_MODE constants MB_INIT_ZERO=0 and MB_INIT_ADDR=1.
  - Function init_word(addr) returning the fill value.
  - Function byte_parity(data) returning a DATA_W/8-bit parity vector.
- One sub-module, mem_rd_pipe: RD_LAT-deep shift register of {valid, rdata, err, perr}, async-reset to all zero.

Test Plan:
- Reset fill (DEPTH=512, INIT_MODE=1, RD_LAT=2):
  - Stimulus: deassert rst.
  - Response: init_done rises 512 cycles later; read addr 0x1FF returns rsp_rdata=0x000001FF with rsp_valid 2 cycles after accept.
- Byte enables:
  - Stimulus: write addr 5, wdata=0xAABBCCDD, be=4'b0101, then read addr 5.
  - Response: rsp_rdata=0x00BB00DD (init value 5 overwritten in bytes 0 and 2).
- Read-after-write pipeline:
  - Stimulus: write addr 10 = 0x12345678 at edge N; read addr 10 at N+1; read addr 11 at N+2.
  - Response: rsp_valid at N+3 with 0x12345678 and at N+4 with 0x0000000B.
- Out-of-range (DEPTH=300):
  - Stimulus: write addr 300 = 0xFFFFFFFF, then read addr 300.
  - Response: rsp_err=1, rsp_rdata=0; addr 44 (300 mod 256) still reads 0x0000002C.
- Reset mid-flight (RD_LAT=4):
  - Stimulus: issue 3 reads, assert rst 2 cycles later.
  - Response: rsp_valid=0 immediately and no responses appear after release; req_ready=0 for 512 cycles.
- Parity (MEM_BANK_PARITY_EN defined):
  - Stimulus: force-flip stored parity of addr 7 byte 1, then read addr 7.
  - Response: rsp_perr=1 and rsp_rdata=0x00000007.
